mult_arbiter: RTL

Two-port round-robin arbiter and sequencer that shares one sequential multiplier between two requesters. It latches the granted requester's operands and issues a one-cycle start pulse to the multiplier. It then tracks the multiplier's ready flag and returns the registered product and sign to the winning requester with a done pulse. A watchdog aborts any operation whose ready flag never arrives and reports an error pulse instead.

---
 rtl/mult_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Two-port round-robin arbiter that shares one sequential multiplier, latching the
// winner's operands, sequencing start/ready, and aborting stalled operations.
module mult_arbiter #(
    parameter int NBits   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [NBits-1:0]     a0,
    input  logic [NBits-1:0]     b0,
    input  logic [NBits-1:0]     a1,
    input  logic [NBits-1:0]     b1,
    output logic                 done0,
    output logic                 done1,
    output logic                 err0,
    output logic                 err1,
    output logic [2*NBits-1:0]   result,
    output logic                 result_sign,
    output logic                 busy,
    output logic                 mult_start,
    output logic [NBits-1:0]     mult_multiplier,
    output logic [NBits-1:0]     mult_multiplicand,
    input  logic [2*NBits-1:0]   mult_product,
    input  logic                 mult_ready,
    input  logic                 mult_sign
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_DELIVER   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [NBits-1:0]   opa_q, opa_d;
    logic [NBits-1:0]   opb_q, opb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*NBits-1:0] result_q, result_d;
    logic               sign_q, sign_d;
    logic               start_q, start_d;
    logic               done0_q, done0_d, done1_q, done1_d;
    logic               err0_q, err0_d, err1_q, err1_d;
    logic               busy_q, busy_d;
    logic               grant1_s;
    logic               expired_s;

    // On a tie the requester that did not win last time takes the grant.
    assign grant1_s  = req1 & (~req0 | ~last_q);
    assign expired_s = (cnt_q == CW'(TIMEOUT - 1));

    // Next-state, datapath and pulse generation; pulses are registered so they
    // appear in the cycle of the state they belong to.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        sign_d   = sign_q;
        start_d  = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    owner_d = grant1_s;
                    last_d  = grant1_s;
                    opa_d   = grant1_s ? a1 : a0;
                    opb_d   = grant1_s ? b1 : b0;
                    start_d = 1'b1;
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                cnt_d = cnt_q + CW'(1);
                if (expired_s) begin
                    err0_d  = ~owner_q;
                    err1_d  = owner_q;
                    state_d = S_IDLE;
                end else if (!mult_ready) begin
                    state_d = S_WAIT_HIGH;
                end else begin
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = cnt_q + CW'(1);
                // A ready arriving in the last allowed cycle still completes.
                if (mult_ready) begin
                    result_d = mult_product;
                    sign_d   = mult_sign;
                    done0_d  = ~owner_q;
                    done1_d  = owner_q;
                    state_d  = S_DELIVER;
                end else if (expired_s) begin
                    err0_d  = ~owner_q;
                    err1_d  = owner_q;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_HIGH;
                end
            end
            S_DELIVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            opa_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            sign_q   <= 1'b0;
            start_q  <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            sign_q   <= sign_d;
            start_q  <= start_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            busy_q   <= busy_d;
        end
    end

    assign done0             = done0_q;
    assign done1             = done1_q;
    assign err0              = err0_q;
    assign err1              = err1_q;
    assign result            = result_q;
    assign result_sign       = sign_q;
    assign busy              = busy_q;
    assign mult_start        = start_q;
    assign mult_multiplier   = opa_q;
    assign mult_multiplicand = opb_q;
endmodule
